// File: rtl/operand_stack_if.sv
// Operand stack bus interface.
//   master : control/ALU side; drives push/push_data/pop/clear_err and reads stack status.
//   slave  : the stack itself; consumes requests and drives tos/count/flags.
// Optional STACK_NOS_EN adds nos/nos_valid (next-on-stack) to the bus.
interface operand_stack_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = $clog2(DEPTH)
);
    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             pop;
    logic             clear_err;
    logic [WIDTH-1:0] tos;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;
`ifdef STACK_NOS_EN
    logic [WIDTH-1:0] nos;
    logic             nos_valid;
`endif

    modport master (
        output push, push_data, pop, clear_err,
`ifdef STACK_NOS_EN
        input  nos, nos_valid,
`endif
        input  tos, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, push_data, pop, clear_err,
`ifdef STACK_NOS_EN
        output nos, nos_valid,
`endif
        output tos, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/operand_stack.sv
// LIFO operand stack feeding the stack-machine ALU.
//   clock    : rising-edge system clock
//   reset    : asynchronous active-high reset (clears count and error flags, not storage)
//   stk_io   : operand_stack_if.slave -- push/pop/clear_err in; tos, count, empty, full,
//              sticky overflow/underflow out.
// Build option: define STACK_NOS_EN to add nos/nos_valid (next-on-stack read port).
// Push and pop together on a non-empty stack replaces the top entry (ALU write-back).
module operand_stack #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    operand_stack_if.slave stk_io
);
    localparam logic [PTR_W:0]   CntOne   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CntDepth = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] IdxOne   = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             empty, full;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] top_idx;
    logic             ovf_set, unf_set;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntDepth);
    // Wraps to DEPTH-1 when full; unused when empty.
    assign top_idx = count_q[PTR_W-1:0] - IdxOne;

    always_comb begin
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = count_q[PTR_W-1:0];
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case ({stk_io.push, stk_io.pop})
            2'b10: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    count_d = count_q + CntOne;
                end
            end
            2'b01: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    count_d = count_q - CntOne;
                end
            end
            2'b11: begin
                wr_en = 1'b1;
                if (empty) begin
                    // Pop fails but the push still lands at the bottom.
                    unf_set = 1'b1;
                    wr_idx  = '0;
                    count_d = CntOne;
                end else begin
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
        // Set wins over a simultaneous clear.
        overflow_d  = ovf_set | (overflow_q & ~stk_io.clear_err);
        underflow_d = unf_set | (underflow_q & ~stk_io.clear_err);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; entries at or above count are don't-care.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_idx] <= stk_io.push_data;
        end
    end

    assign stk_io.tos       = empty ? '0 : mem_q[top_idx];
    assign stk_io.count     = count_q;
    assign stk_io.empty     = empty;
    assign stk_io.full      = full;
    assign stk_io.overflow  = overflow_q;
    assign stk_io.underflow = underflow_q;

`ifdef STACK_NOS_EN
    localparam logic [PTR_W:0]   CntTwo = (PTR_W + 1)'(2);
    localparam logic [PTR_W-1:0] IdxTwo = PTR_W'(2);
    logic [PTR_W-1:0] nos_idx;
    assign nos_idx          = count_q[PTR_W-1:0] - IdxTwo;
    assign stk_io.nos_valid = (count_q >= CntTwo);
    assign stk_io.nos       = stk_io.nos_valid ? mem_q[nos_idx] : '0;
`endif
endmodule
